// File: rtl/ps2_host_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx_if
// Purpose  : Command/status bundle between a client and the PS/2 host-to-device
//            transmitter.
// Signals  : tx_data[7:0] command byte, tx_valid request, tx_ready accept,
//            busy frame in progress, done / err one-cycle frame-end pulses,
//            ack_ok device-acknowledge flag (valid with done/err).
// Modports : master - client issuing commands; slave - the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_ok,
        input  err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output ack_ok,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device transmitter. Sends one command byte to the
//            keyboard by open-drain drive of the PS/2 clock/data lines and
//            checks the device acknowledge bit. busy gates the companion
//            receiver while a frame is on the wire.
// Ports    : clk         system clock
//            res_n       asynchronous reset, active low
//            tx          ps2_host_tx_if.slave (tx_data, tx_valid, tx_ready,
//                        busy, done, ack_ok, err)
//            ps2clk_in   PS/2 clock pin level (asynchronous)
//            ps2data_in  PS/2 data pin level (asynchronous)
//            ps2clk_oe   1 = pull PS/2 clock low, 0 = release
//            ps2data_oe  1 = pull PS/2 data low, 0 = release
// Params   : CLK_HZ, INHIBIT_US, TIMEOUT_US, FILTER_LEN
// Options  : PS2_TX_RESEND_EN - when defined, a NACK or timeout retransmits
//            the same byte from the inhibit phase, up to 2 retries.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_US = 20000,
    parameter int FILTER_LEN = 8
) (
    input  logic         clk,
    input  logic         res_n,
    ps2_host_tx_if.slave tx,
    input  logic         ps2clk_in,
    input  logic         ps2data_in,
    output logic         ps2clk_oe,
    output logic         ps2data_oe
);

    // ------------------------------------------------------------------------
    // Timing constants (64-bit math: default INHIBIT/TIMEOUT products exceed
    // 32 bits before the division).
    // ------------------------------------------------------------------------
    localparam longint C_INH_RAW = (longint'(INHIBIT_US) * longint'(CLK_HZ)) / 64'sd1_000_000;
    localparam longint C_INH_CYC = (C_INH_RAW < 1) ? 64'sd1 : C_INH_RAW;
    localparam longint C_TO_RAW  = (longint'(TIMEOUT_US) * longint'(CLK_HZ)) / 64'sd1_000_000;
    localparam longint C_TO_CYC  = (C_TO_RAW < 1) ? 64'sd1 : C_TO_RAW;
    localparam longint C_REQ_CYC = 64'sd16;
    localparam longint C_TMR_MAX = (C_INH_CYC > C_REQ_CYC) ? C_INH_CYC : C_REQ_CYC;

    localparam int C_TMR_W = $clog2(C_TMR_MAX + 1);
    localparam int C_TO_W  = $clog2(C_TO_CYC + 1);
    localparam int C_FLT_W = $clog2(FILTER_LEN + 1);

    localparam logic [C_TMR_W-1:0] C_INH_LAST = C_TMR_W'(C_INH_CYC - 1);
    localparam logic [C_TMR_W-1:0] C_REQ_LAST = C_TMR_W'(C_REQ_CYC - 1);
    localparam logic [C_TO_W-1:0]  C_TO_LAST  = C_TO_W'(C_TO_CYC - 1);
    localparam logic [C_FLT_W-1:0] C_FLT_LAST = C_FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_REQ     = 3'd2,
        S_START   = 3'd3,
        S_ACK     = 3'd4,
        S_WAITI   = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Input conditioning: 2-FF synchroniser followed by a stability filter.
    // Index 0 = PS/2 clock, index 1 = PS/2 data. Both idle high.
    // ------------------------------------------------------------------------
    logic [1:0] w_pin;
    logic [1:0] w_flt;

    assign w_pin = {ps2data_in, ps2clk_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        logic [1:0]         r_sync;
        logic [C_FLT_W-1:0] r_cnt;
        logic               r_lvl;

        // The accepted level only follows the synchronised pin after it has
        // differed for FILTER_LEN consecutive cycles; any return to the
        // accepted level restarts the count, so short glitches vanish.
        always_ff @(posedge clk or negedge res_n) begin
            if (!res_n) begin
                r_sync <= 2'b11;
                r_cnt  <= '0;
                r_lvl  <= 1'b1;
            end else begin
                r_sync <= {r_sync[0], w_pin[gi]};
                if (r_sync[1] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_FLT_LAST) begin
                    r_lvl <= r_sync[1];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_flt[gi] = r_lvl;
    end

    logic r_clk_d;
    logic w_clk_fall;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_clk_d <= 1'b1;
        end else begin
            r_clk_d <= w_flt[0];
        end
    end

    assign w_clk_fall = r_clk_d & ~w_flt[0];

    // ------------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [9:0]          r_shift;     // {stop, parity, data[7:0]}, LSB goes first
    logic [3:0]          r_bit_cnt;
    logic [C_TMR_W-1:0]  r_tmr;       // inhibit / request-to-send timer
    logic [C_TO_W-1:0]   r_to_cnt;    // frame timeout counter
    logic                r_acked;     // device pulled data low at 11th edge
    logic                r_clk_oe;
    logic                r_data_oe;
    logic                r_tx_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_ack_ok;
`ifdef PS2_TX_RESEND_EN
    logic [9:0]          r_resend;    // frame image kept for retransmission
    logic [1:0]          r_retry;     // retries already used for this byte
`endif

    logic w_in_frame;
    logic w_lines_idle;
    logic w_timeout;
    logic w_frame_ok;
    logic w_nack;
    logic w_fail;

    assign w_in_frame   = (r_state == S_START) || (r_state == S_ACK) || (r_state == S_WAITI);
    assign w_lines_idle = w_flt[0] & w_flt[1];
    // Timeout is evaluated ahead of any edge handling so it wins a tie.
    assign w_timeout    = w_in_frame && (r_to_cnt == C_TO_LAST);
    assign w_frame_ok   = (r_state == S_WAITI) && w_lines_idle &&  r_acked;
    assign w_nack       = (r_state == S_WAITI) && w_lines_idle && !r_acked;
    assign w_fail       = w_timeout | w_nack;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_tmr      <= '0;
            r_to_cnt   <= '0;
            r_acked    <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ack_ok   <= 1'b0;
`ifdef PS2_TX_RESEND_EN
            r_resend   <= '0;
            r_retry    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_fail) begin
`ifdef PS2_TX_RESEND_EN
                if (r_retry != 2'd2) begin
                    // Retry: go straight back to inhibit with the same byte;
                    // busy stays asserted and no status pulse is raised.
                    r_retry   <= r_retry + 2'd1;
                    r_shift   <= r_resend;
                    r_state   <= S_INHIBIT;
                    r_clk_oe  <= 1'b1;
                    r_data_oe <= 1'b0;
                    r_tmr     <= '0;
                    r_acked   <= 1'b0;
                end else
`endif
                begin
                    r_state    <= S_IDLE;
                    r_clk_oe   <= 1'b0;
                    r_data_oe  <= 1'b0;
                    r_err      <= 1'b1;
                    r_ack_ok   <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            end else if (w_frame_ok) begin
                r_state    <= S_IDLE;
                r_clk_oe   <= 1'b0;
                r_data_oe  <= 1'b0;
                r_done     <= 1'b1;
                r_ack_ok   <= 1'b1;
                r_tx_ready <= 1'b1;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                        if (tx.tx_valid && r_tx_ready) begin
                            r_shift    <= {1'b1, ~^tx.tx_data, tx.tx_data};
`ifdef PS2_TX_RESEND_EN
                            r_resend   <= {1'b1, ~^tx.tx_data, tx.tx_data};
                            r_retry    <= '0;
`endif
                            r_state    <= S_INHIBIT;
                            r_tx_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_clk_oe   <= 1'b1;
                            r_tmr      <= '0;
                            r_acked    <= 1'b0;
                        end
                    end

                    S_INHIBIT: begin
                        if (r_tmr == C_INH_LAST) begin
                            r_tmr     <= '0;
                            r_state   <= S_REQ;
                            r_data_oe <= 1'b1;
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end

                    S_REQ: begin
                        if (r_tmr == C_REQ_LAST) begin
                            // Release clock, keep data low as the start bit.
                            r_tmr     <= '0;
                            r_state   <= S_START;
                            r_clk_oe  <= 1'b0;
                            r_to_cnt  <= '0;
                            r_bit_cnt <= '0;
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end

                    S_START: begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (w_clk_fall) begin
                            // Open drain: a '1' bit means release the line.
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[9:1]};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd9) begin
                                r_state <= S_ACK;
                            end
                        end
                    end

                    S_ACK: begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (w_clk_fall) begin
                            r_acked <= ~w_flt[1];
                            r_state <= S_WAITI;
                        end
                    end

                    S_WAITI: begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end

                    default: begin
                        r_state    <= S_IDLE;
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx.tx_ready = r_tx_ready;
    assign tx.busy     = r_busy;
    assign tx.done     = r_done;
    assign tx.ack_ok   = r_ack_ok;
    assign tx.err      = r_err;
    assign ps2clk_oe   = r_clk_oe;
    assign ps2data_oe  = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx with a keyboard-side model
//            that clocks frames, captures the bits and answers ACK or NACK.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int CLK_HZ     = 1_000_000;
    localparam int INHIBIT_US = 20;
    localparam int TIMEOUT_US = 2000;
    localparam int FILTER_LEN = 8;
    localparam int C_INH      = 20;     // INHIBIT_US * CLK_HZ / 1e6
    localparam int C_REQ      = 16;
    localparam int C_TO       = 2000;   // TIMEOUT_US * CLK_HZ / 1e6
    localparam int HALF       = 20;     // device clock half period in cycles
`ifdef PS2_TX_RESEND_EN
    localparam int TRIES      = 3;
`else
    localparam int TRIES      = 1;
`endif

    logic clk   = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    logic ps2clk_oe;
    logic ps2data_oe;
    logic ps2clk_in;
    logic ps2data_in;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    // Wired-AND open-drain lines with pull-ups.
    assign ps2clk_in  = ~(ps2clk_oe  | dev_clk_low);
    assign ps2data_in = ~(ps2data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_US (TIMEOUT_US),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .tx         (bus),
        .ps2clk_in  (ps2clk_in),
        .ps2data_in (ps2data_in),
        .ps2clk_oe  (ps2clk_oe),
        .ps2data_oe (ps2data_oe)
    );

    // ------------------------------------------------------------------------
    // Line / status monitor
    // ------------------------------------------------------------------------
    int   cyc          = 0;
    int   n_done       = 0;
    int   n_err        = 0;
    int   n_inh        = 0;
    int   inh_len      = 0;
    int   last_inh_len = 0;
    int   last_start   = 0;
    int   err_cyc      = 0;
    logic last_ack     = 1'b0;
    logic prev_coe     = 1'b0;

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_coe <= ps2clk_oe;
        if (ps2clk_oe) inh_len <= inh_len + 1;
        if (ps2clk_oe && !prev_coe) begin
            n_inh   <= n_inh + 1;
            inh_len <= 1;
        end
        if (!ps2clk_oe && prev_coe) begin
            last_inh_len <= inh_len;
            if (ps2data_oe) last_start <= cyc;
        end
        if (bus.done) n_done <= n_done + 1;
        if (bus.err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
        if (bus.done || bus.err) last_ack <= bus.ack_ok;
    end

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic handshake(input logic [7:0] data);
        int c;
        c = 0;
        while (!bus.tx_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("tx_ready_before_send", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = data;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        int c;
        c  = 0;
        ok = 1'b0;
        while (c < 500) begin
            @(negedge clk);
            if (!ps2clk_oe && ps2data_oe && bus.busy) begin
                ok = 1'b1;
                break;
            end
            c++;
        end
    endtask

    task automatic dev_pulse(output logic smp);
        @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF - 1) @(negedge clk);
        smp = ps2data_in;                  // device samples just before rising
        @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - 1) @(negedge clk);
    endtask

    task automatic dev_frame(input bit ack, input bit glitch, output logic [9:0] bits);
        logic s;
        bits = '0;
        repeat (30) @(negedge clk);
        if (glitch) begin
            bus.tx_data  = 8'h00;          // request while busy: must be ignored
            bus.tx_valid = 1'b1;
            dev_clk_low  = 1'b1;
            repeat (3) @(negedge clk);
            dev_clk_low  = 1'b0;
            repeat (20) @(negedge clk);
            chk("glitch_no_shift", 32'(ps2data_oe), 32'd1);
            chk("busy_during_frame", 32'(bus.tx_ready), 32'd0);
            bus.tx_valid = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            dev_pulse(s);
            bits[k] = s;
        end
        if (ack) dev_data_low = 1'b1;
        repeat (15) @(negedge clk);
        dev_pulse(s);
        dev_data_low = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] data, input int n_nack, input bit glitch,
                        output logic [9:0] bits, output int d, output int e,
                        output logic a, output int inh);
        int d0, e0, i0, c;
        bit ok;
        d0 = n_done;
        e0 = n_err;
        i0 = n_inh;
        bits = '0;
        handshake(data);
        for (int t = 0; t < TRIES; t++) begin
            wait_start(ok);
            if (!ok) begin
                chk("start_seen", 32'd0, 32'd1);
                break;
            end
            dev_frame(t >= n_nack, glitch && (t == 0), bits);
            if (t >= n_nack) break;
        end
        c = 0;
        while (n_done == d0 && n_err == e0 && c < 300) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        d   = n_done - d0;
        e   = n_err - e0;
        a   = last_ack;
        inh = n_inh - i0;
    endtask

    // ------------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        int         n_nack;
        logic [9:0] bits;     // {stop, parity, data}, bit 0 sent first
        int         done;
        int         err;
        logic       ack;
        int         inh;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [9:0] bits;
        int         d, e, inh, e0, i0, c;
        logic       a;
        bit         ok;
        logic       s;

        vecs[0] = '{8'hED, 0, 10'h3ED, 1, 0, 1'b1, 1};
        vecs[1] = '{8'h00, 0, 10'h300, 1, 0, 1'b1, 1};
        vecs[2] = '{8'hFF, 0, 10'h3FF, 1, 0, 1'b1, 1};
        vecs[3] = '{8'h01, 0, 10'h201, 1, 0, 1'b1, 1};
        vecs[4] = '{8'hF4, 3, 10'h2F4, 0, 1, 1'b0, TRIES};
`ifdef PS2_TX_RESEND_EN
        vecs[5] = '{8'hF4, 2, 10'h2F4, 1, 0, 1'b1, 3};
`else
        vecs[5] = '{8'hED, 1, 10'h3ED, 0, 1, 1'b0, 1};
`endif

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({bus.tx_ready, bus.busy, bus.done, bus.ack_ok, bus.err, ps2clk_oe, ps2data_oe}),
            32'd0);
        res_n = 1'b1;
        @(negedge clk);
        chk("tx_ready_after_reset", 32'(bus.tx_ready), 32'd1);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            xfer(vecs[i].data, vecs[i].n_nack, 1'b0, bits, d, e, a, inh);
            chk($sformatf("v%0d_bits", i),    32'(bits), 32'(vecs[i].bits));
            chk($sformatf("v%0d_done", i),    32'(d),    32'(vecs[i].done));
            chk($sformatf("v%0d_err", i),     32'(e),    32'(vecs[i].err));
            chk($sformatf("v%0d_ack_ok", i),  32'(a),    32'(vecs[i].ack));
            chk($sformatf("v%0d_inhibits", i), 32'(inh), 32'(vecs[i].inh));
            chk($sformatf("v%0d_inh_len", i), 32'(last_inh_len), 32'(C_INH + C_REQ));
            chk($sformatf("v%0d_idle", i),
                32'({bus.tx_ready, bus.busy, ps2clk_oe, ps2data_oe}), 32'b1000);
        end

        // Device never clocks: abort exactly C_TO cycles after START entry.
        e0 = n_err;
        handshake(8'h55);
        c = 0;
        while (n_err == e0 && c < TRIES * (C_TO + 200)) begin
            @(negedge clk);
            c++;
        end
        chk("timeout_err", 32'(n_err - e0), 32'd1);
        chk("timeout_cycles", 32'(err_cyc - last_start), 32'(C_TO));
        chk("timeout_state",
            32'({bus.tx_ready, bus.busy, bus.ack_ok, ps2clk_oe, ps2data_oe}), 32'b10000);

        // Reset in the middle of the frame, after data edge 4.
        handshake(8'h30);
        wait_start(ok);
        chk("rst_start_seen", 32'(ok), 32'd1);
        repeat (30) @(negedge clk);
        for (int k = 0; k < 4; k++) dev_pulse(s);
        @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_lines", 32'({ps2clk_oe, ps2data_oe}), 32'b01);
        #2 res_n = 1'b0;
        #1;
        chk("rst_lines_released", 32'({ps2clk_oe, ps2data_oe, bus.busy}), 32'd0);
        dev_clk_low = 1'b0;
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        repeat (20) @(negedge clk);
        xfer(8'hFF, 0, 1'b0, bits, d, e, a, inh);
        chk("post_rst_bits", 32'(bits), 32'h3FF);
        chk("post_rst_done", 32'({d[1:0], e[1:0], a}), 32'b01001);

        // Clock glitch during START plus a request while busy.
        i0 = n_inh;
        xfer(8'hA5, 0, 1'b1, bits, d, e, a, inh);
        chk("glitch_bits", 32'(bits), 32'h3A5);
        chk("glitch_done", 32'({d[1:0], e[1:0], a}), 32'b01001);
        repeat (100) @(negedge clk);
        chk("no_queued_frame", 32'(n_inh - i0), 32'd1);
        chk("idle_after_glitch", 32'({bus.tx_ready, bus.busy}), 32'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
